sha256_message_schedule: RTL and testbench

SHA256_MESSAGE_SCHEDULE -- requirements
Module: sha256_message_schedule

---
 rtl/sha256_message_schedule_pkg.sv | 10 +
 rtl/sha256_message_schedule_if.sv | 22 ++
 rtl/sha256_sigma_lower.sv | 13 +
 rtl/sha256_message_schedule.sv | 52 +++++
 tb/tb_sha256_message_schedule.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sha256_message_schedule_pkg.sv
// sha256_message_schedule_pkg: shared SHA-2 schedule state, word type, round count and rotate helper
package sha256_message_schedule_pkg;
  typedef enum logic {IDLE, EXPAND} state_t;
  typedef logic [31:0] word_t;
  localparam int ROUNDS = 64;
  localparam int ROUND_W = $clog2(ROUNDS);
  function automatic word_t rotr(word_t x, int n);
    return (x >> n) | (x << (32 - n));
  endfunction
endpackage

// File: rtl/sha256_message_schedule_if.sv
// sha256_message_schedule_if: block input and schedule-word output handshakes
interface sha256_message_schedule_if;
  import sha256_message_schedule_pkg::*;
  logic [511:0] data_in;
  logic data_in_last;
  logic data_in_valid;
  logic data_in_ready;
  word_t data_out;
  logic [ROUND_W-1:0] data_out_round;
  logic data_out_block_last;
  logic data_out_last;
  logic data_out_valid;
  logic data_out_ready;
  modport master (
    output data_in, data_in_last, data_in_valid, data_out_ready,
    input data_in_ready, data_out, data_out_round, data_out_block_last, data_out_last, data_out_valid
  );
  modport slave (
    input data_in, data_in_last, data_in_valid, data_out_ready,
    output data_in_ready, data_out, data_out_round, data_out_block_last, data_out_last, data_out_valid
  );
endinterface

// File: rtl/sha256_sigma_lower.sv
// sha256_sigma_lower: lower-case SHA-256 sigma, rotate/shift amounts chosen by parameters
module sha256_sigma_lower
  import sha256_message_schedule_pkg::*;
#(
  parameter int R1 = 7,
  parameter int R2 = 18,
  parameter int SH = 3
) (
  input  word_t x,
  output word_t y
);
  assign y = rotr(x, R1) ^ rotr(x, R2) ^ (x >> SH);
endmodule

// File: rtl/sha256_message_schedule.sv
// sha256_message_schedule: expands a 512-bit block into 64 schedule words, one per handshake
module sha256_message_schedule
  import sha256_message_schedule_pkg::*;
(
  input logic clk,
  input logic nrst,
  sha256_message_schedule_if.slave bus
);
  state_t state;
  logic [15:0][31:0] w;
  logic [ROUND_W-1:0] round;
  logic last_q;
  logic ready_q;
  word_t s0;
  word_t s1;
  word_t next_w;
  logic take;
  // w[15] holds W_t, w[0] holds W_t+15
  sha256_sigma_lower #(.R1(7), .R2(18), .SH(3)) u_s0 (.x(w[14]), .y(s0));
  sha256_sigma_lower #(.R1(17), .R2(19), .SH(10)) u_s1 (.x(w[1]), .y(s1));
  assign next_w = s1 + w[6] + s0 + w[15];
  assign take = ready_q && bus.data_in_valid;
  assign bus.data_in_ready = ready_q;
  assign bus.data_out_valid = state == EXPAND;
  assign bus.data_out = w[15];
  assign bus.data_out_round = round;
  assign bus.data_out_block_last = round == ROUND_W'(ROUNDS - 1);
  assign bus.data_out_last = bus.data_out_block_last && last_q;
  always_ff @(posedge clk or posedge nrst)
    if (nrst) begin
      state <= IDLE;
      w <= '0;
      round <= '0;
      last_q <= 1'b0;
      ready_q <= 1'b0;
    end else if (state == IDLE) begin
      ready_q <= !take;
      if (take) begin
        w <= bus.data_in;
        last_q <= bus.data_in_last;
        round <= '0;
        state <= EXPAND;
      end
    end else if (bus.data_out_ready) begin
      w <= {w[14:0], next_w};
      round <= round + 1'b1;
      if (bus.data_out_block_last) begin
        state <= IDLE;
        ready_q <= 1'b1;
      end
    end
endmodule

// File: tb/tb_sha256_message_schedule.sv
// tb_sha256_message_schedule: directed checks of the SHA-256 message schedule against a software model
module tb_sha256_message_schedule;
  logic clk = 1'b0;
  logic nrst = 1'b1;
  int checks = 0;
  int failures = 0;
  logic [31:0] exp_w [64];
  logic [31:0] exp_a [64];
  logic [511:0] abc_blk;
  logic [511:0] blk2;

  sha256_message_schedule_if b ();
  sha256_message_schedule dut (.clk(clk), .nrst(nrst), .bus(b));

  always #5 clk = ~clk;

  function automatic logic [31:0] rr(logic [31:0] x, int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic void model(logic [511:0] blk);
    for (int i = 0; i < 64; i++)
      if (i < 16) exp_w[i] = blk[511 - 32*i -: 32];
      else exp_w[i] = (rr(exp_w[i-2], 17) ^ rr(exp_w[i-2], 19) ^ (exp_w[i-2] >> 10)) + exp_w[i-7]
                    + (rr(exp_w[i-15], 7) ^ rr(exp_w[i-15], 18) ^ (exp_w[i-15] >> 3)) + exp_w[i-16];
  endfunction

  function automatic logic [31:0] hand_abc(int t);
    case (t)
      0, 16: return 32'h61626380;
      15: return 32'h00000018;
      17: return 32'h000F0000;
      default: return 32'h7DA86405;
    endcase
  endfunction

  task automatic send_block(logic [511:0] blk, logic l);
    int cyc = 0;
    b.data_in = blk;
    b.data_in_last = l;
    b.data_in_valid = 1'b1;
    while (b.data_in_ready !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (b.data_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL send_timeout ready=%b want 1", b.data_in_ready);
    end
    @(negedge clk);
    b.data_in_valid = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if ({b.data_in_ready, b.data_out_valid, b.data_out, b.data_out_round, b.data_out_last, b.data_out_block_last} !== '0) begin
      failures++;
      $display("FAIL reset_outputs ready=%b valid=%b data=%h round=%0d want all 0", b.data_in_ready, b.data_out_valid, b.data_out, b.data_out_round);
    end
    @(negedge clk);
    nrst = 1'b0;
    @(negedge clk);
    checks++;
    if (b.data_in_ready !== 1'b1 || b.data_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release ready=%b valid=%b want 1 0", b.data_in_ready, b.data_out_valid);
    end
  endtask

  task automatic test_abc;
    int t = 0;
    int cyc = 0;
    model(abc_blk);
    b.data_out_ready = 1'b1;
    send_block(abc_blk, 1'b1);
    while (t < 64 && cyc < 200) begin
      if (b.data_out_valid === 1'b1) begin
        checks++;
        if (b.data_out !== exp_w[t] || b.data_out_round !== 6'(t) || b.data_out_block_last !== (t == 63) || b.data_out_last !== (t == 63)) begin
          failures++;
          $display("FAIL abc_word t=%0d got %h r=%0d bl=%b l=%b want %h", t, b.data_out, b.data_out_round, b.data_out_block_last, b.data_out_last, exp_w[t]);
        end
        if (t == 0 || (t >= 15 && t <= 18)) begin
          checks++;
          if (b.data_out !== hand_abc(t)) begin
            failures++;
            $display("FAIL abc_known t=%0d got %h want %h", t, b.data_out, hand_abc(t));
          end
        end
        t++;
      end
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (t != 64 || b.data_in_ready !== 1'b1 || b.data_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL abc_end words=%0d ready=%b valid=%b want 64 1 0", t, b.data_in_ready, b.data_out_valid);
    end
  endtask

  task automatic test_stall;
    int t = 0;
    int cyc = 0;
    model(abc_blk);
    send_block(abc_blk, 1'b1);
    while (t < 64 && cyc < 2000) begin
      b.data_out_ready = 1'($urandom_range(0, 1));
      if (b.data_out_valid === 1'b1) begin
        checks++;
        if (b.data_out !== exp_w[t] || b.data_out_round !== 6'(t) || b.data_out_last !== (t == 63)) begin
          failures++;
          $display("FAIL stall_word t=%0d got %h r=%0d l=%b want %h", t, b.data_out, b.data_out_round, b.data_out_last, exp_w[t]);
        end
        if (b.data_out_ready) t++;
      end
      @(negedge clk);
      cyc++;
    end
    b.data_out_ready = 1'b1;
    checks++;
    if (t != 64) begin
      failures++;
      $display("FAIL stall_timeout words=%0d want 64", t);
    end
  endtask

  task automatic test_back_to_back;
    int n = 0;
    int cyc = 0;
    int gap = 0;
    int t;
    logic [31:0] e;
    model(blk2);
    exp_a = exp_w;
    model(abc_blk);
    b.data_out_ready = 1'b1;
    b.data_in = blk2;
    b.data_in_last = 1'b0;
    b.data_in_valid = 1'b1;
    while (b.data_in_ready !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    b.data_in = abc_blk;
    b.data_in_last = 1'b1;
    cyc = 0;
    while (n < 128 && cyc < 400) begin
      t = n % 64;
      e = n < 64 ? exp_a[t] : exp_w[t];
      if (b.data_out_valid === 1'b1) begin
        checks++;
        if (b.data_out !== e || b.data_out_round !== 6'(t) || b.data_out_block_last !== (t == 63)
            || b.data_out_last !== (n == 127) || b.data_in_ready !== 1'b0) begin
          failures++;
          $display("FAIL b2b_word n=%0d got %h r=%0d bl=%b l=%b rdy=%b want %h", n, b.data_out, b.data_out_round, b.data_out_block_last, b.data_out_last, b.data_in_ready, e);
        end
        if (n == 64) b.data_in_valid = 1'b0;
        n++;
      end else begin
        gap++;
        checks++;
        if (n != 64 || b.data_in_ready !== 1'b1) begin
          failures++;
          $display("FAIL b2b_gap n=%0d ready=%b want n=64 ready=1", n, b.data_in_ready);
        end
      end
      @(negedge clk);
      cyc++;
    end
    b.data_in_valid = 1'b0;
    checks++;
    if (n != 128 || gap != 1) begin
      failures++;
      $display("FAIL b2b_count words=%0d gap=%0d want 128 1", n, gap);
    end
  endtask

  task automatic test_reset_mid;
    int t = 0;
    int cyc = 0;
    model(blk2);
    b.data_out_ready = 1'b1;
    send_block(blk2, 1'b1);
    while (t < 30 && cyc < 200) begin
      if (b.data_out_valid === 1'b1) t++;
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (b.data_out_round !== 6'd30 || b.data_out !== exp_w[30]) begin
      failures++;
      $display("FAIL mid_pre round=%0d data=%h want 30 %h", b.data_out_round, b.data_out, exp_w[30]);
    end
    nrst = 1'b1;
    #1;
    checks++;
    if ({b.data_in_ready, b.data_out_valid, b.data_out, b.data_out_round, b.data_out_last, b.data_out_block_last} !== '0) begin
      failures++;
      $display("FAIL mid_async ready=%b valid=%b data=%h round=%0d want all 0", b.data_in_ready, b.data_out_valid, b.data_out, b.data_out_round);
    end
    @(negedge clk);
    nrst = 1'b0;
    @(negedge clk);
    checks++;
    if (b.data_in_ready !== 1'b1 || b.data_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_release ready=%b valid=%b want 1 0", b.data_in_ready, b.data_out_valid);
    end
    model(abc_blk);
    send_block(abc_blk, 1'b0);
    t = 0;
    cyc = 0;
    while (t < 64 && cyc < 200) begin
      if (b.data_out_valid === 1'b1) begin
        checks++;
        if (b.data_out !== exp_w[t] || b.data_out_round !== 6'(t) || b.data_out_last !== 1'b0) begin
          failures++;
          $display("FAIL mid_restart t=%0d got %h r=%0d l=%b want %h", t, b.data_out, b.data_out_round, b.data_out_last, exp_w[t]);
        end
        t++;
      end
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (t != 64) begin
      failures++;
      $display("FAIL mid_timeout words=%0d want 64", t);
    end
  endtask

  initial begin
    abc_blk = {32'h61626380, 448'h0, 32'h00000018};
    for (int i = 0; i < 16; i++) blk2[511 - 32*i -: 32] = 32'h9E3779B9 * (i + 1) ^ 32'h0F0F1234;
    b.data_in = '0;
    b.data_in_last = 1'b0;
    b.data_in_valid = 1'b0;
    b.data_out_ready = 1'b0;
    test_reset();
    test_abc();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
